rv32i_writeback: RTL and testbench
==================================

Name: rv32i_writeback

Overview:
- Write-side companion to the register file: the single producer of its wrt_en, oprd and wrt_data inputs.
- Accepts results from the ALU (single-cycle) and the load unit (variable latency) over valid/ready handshakes.
- Buffers results in a small in-order queue and retires one register write per cycle.
- Provides forwarding of pending results to the decode-stage read addresses oprs1/oprs2.

Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- XLEN, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result valid
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- mem_valid  in  1  load result valid
- mem_rd  in  AW  load destination register
- mem_data  in  XLEN  load data, already sign/zero extended
- mem_ready  out  1  load result accepted this cycle
- wb_stall  in  1  hold draining (register port borrowed)
- wrt_en  out  1  register file write enable
- oprd  out  AW  register file write address
- wrt_data  out  XLEN  register file write data
- oprs1  in  AW  decode read address 1
- oprs2  in  AW  decode read address 2
- fwd1_hit  out  1  pending value exists for oprs1
- fwd1_data  out  XLEN  youngest pending value for oprs1
- fwd2_hit  out  1  as fwd1, for oprs2
- fwd2_data  out  XLEN  as fwd1, for oprs2
- pending  out  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Reset (rst=0, asynchronous):
  - queue emptied, pointers and pending = 0
  - wrt_en = 0, oprd = 0, wrt_data = 0
  - both ready outputs = 0 while rst is low
- Acceptance:
  - At most one result accepted per cycle; mem has priority over alu (loads are older).
  - mem_ready = (pending < DEPTH).
  - alu_ready = (pending < DEPTH) && !mem_valid.
  - A transfer occurs when valid && ready at the rising edge.
  - Producers must hold rd/data stable while valid && !ready.
- x0 suppression: an accepted result with rd = 0 is consumed (ready asserted as normal) but not enqueued, so pending is unchanged.
- Drain:
  - Each cycle with pending > 0 and wb_stall = 0, the head is popped into registered outputs: wrt_en = 1, oprd = head.rd, wrt_data = head.data.
  - Otherwise wrt_en = 0 and oprd/wrt_data hold their previous values.
- Latency: a result accepted at edge N with an empty queue and no stall appears with wrt_en = 1 after edge N+1.
  - The register file writes at edge N+2.
- Simultaneous push and pop in the same cycle: pending unchanged. This is legal when full, but ready is computed from the registered pending, so no push is accepted when full.
- Full: pending = DEPTH implies both ready outputs low, and the queue holds contents and order.
- Wrap-around: read and write pointers are AW-independent, log2(DEPTH) bits, and wrap modulo DEPTH. Full and empty are derived from pending.
- Forwarding (combinational, same cycle):
  - Candidates are all valid queue entries plus the output register while wrt_en = 1 (its write has not yet taken effect).
  - fwdX_hit = 1 if any candidate rd == oprsX and oprsX != 0.
  - fwdX_data is taken from the youngest matching candidate. Youngest is the most recently enqueued entry; the output register is the oldest.
  - With no match, hit = 0 and data = 0.
- wb_stall high mid-operation: queue keeps accepting until full and wrt_en drops the next cycle. No entry is lost or duplicated.
- Reset asserted mid-operation: queued results are discarded. This is acceptable because the pipeline flushes on reset.

Decomposition:
- Shared package rv32i_pkg holds XLEN, AW, the REG_ZERO constant, and a wb_entry_t typedef {rd, data}.
- One sub-module, rv32i_wb_fifo: a DEPTH-entry circular buffer exposing push, pop, head, occupancy and a flat entry/valid view for the forwarding compare.
- Acceptance arbitration, drain register and forward search stay in rv32i_writeback.

Test Plan:
- Reset then single ALU result: alu rd=5, data=0x0000_00AA for one cycle → alu_ready=1; one cycle later wrt_en=1, oprd=5, wrt_data=0xAA; pending returns to 0.
- Simultaneous sources: mem rd=3, data=0x1111 and alu rd=4, data=0x2222 both valid → mem accepted first, alu_ready=0 that cycle; writes retire in order x3=0x1111 then x4=0x2222.
- x0 drop: alu rd=0, data=0xDEAD → alu_ready=1; pending stays 0, wrt_en never asserts, and oprs1=0 gives fwd1_hit=0.
- Fill under stall: wb_stall=1 and 5 ALU results (rd=1..5) → first 4 accepted, pending=4, alu_ready=0 on the 5th; release stall → 5 writes in order rd=1..5 with wrt_en high on consecutive cycles.
- Forward youngest: with wb_stall=1, enqueue rd=7 data=0x10, then rd=7 data=0x20, and set oprs2=7 → fwd2_hit=1, fwd2_data=0x20; after both retire, fwd2_hit=0.
- Async reset mid-drain: with 3 entries pending, pull rst low between edges → wrt_en=0, pending=0 immediately; after release, no stale writes occur.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I register write-back path.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rv32i_wb_fifo.sv
// In-order circular buffer of pending register writes, with an age-ordered view
// of every slot so the forwarding search can find the youngest match.
module rv32i_wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output wb_entry_t                    entries [DEPTH],
  output logic [DEPTH-1:0]             valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // NOTE: storage carries no reset; an entry is only ever read while count marks it valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Slot 0 is the oldest entry, slot DEPTH-1 the youngest possible.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PW'(k)];
      valid[k]   = (k < int'(count));
    end
  end

endmodule

// File: rtl/rv32i_writeback.sv
// Write-back stage: arbitrates ALU/load results into an in-order queue, retires one
// register write per cycle and forwards pending values to the decode read ports.
module rv32i_writeback
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [AW-1:0]               alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  output logic                        alu_ready,
  input  logic                        mem_valid,
  input  logic [AW-1:0]               mem_rd,
  input  logic [XLEN-1:0]             mem_data,
  output logic                        mem_ready,
  input  logic                        wb_stall,
  output logic                        wrt_en,
  output logic [AW-1:0]               oprd,
  output logic [XLEN-1:0]             wrt_data,
  input  logic [AW-1:0]               oprs1,
  input  logic [AW-1:0]               oprs2,
  output logic                        fwd1_hit,
  output logic [XLEN-1:0]             fwd1_data,
  output logic                        fwd2_hit,
  output logic [XLEN-1:0]             fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0]  pending
);

  localparam int CW = $clog2(DEPTH+1);

  logic       full;
  logic       mem_fire;
  logic       alu_fire;
  logic       push;
  logic       pop;
  wb_entry_t  in_entry;
  wb_entry_t  head;
  wb_entry_t  entries [DEPTH];
  logic [DEPTH-1:0] valid;

  // Ready is gated by rst so producers never see a handshake during reset.
  assign full      = (pending == CW'(DEPTH));
  assign mem_ready = rst && !full;
  assign alu_ready = rst && !full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;

  assign in_entry = mem_fire ? '{rd: mem_rd, data: mem_data}
                             : '{rd: alu_rd, data: alu_data};
  // Writes to x0 complete the handshake but never occupy a slot.
  assign push = (mem_fire || alu_fire) && (in_entry.rd != REG_ZERO);
  assign pop  = (pending != '0) && !wb_stall;

  rv32i_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .head       (head),
    .count      (pending),
    .entries    (entries),
    .valid      (valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrt_en   <= 1'b0;
      oprd     <= '0;
      wrt_data <= '0;
    end else begin
      wrt_en <= pop;
      if (pop) begin
        oprd     <= head.rd;
        wrt_data <= head.data;
      end
    end
  end

  // The output register is the oldest candidate, so it is checked first and any
  // queue match, scanned oldest to youngest, overrides it.
  logic [AW-1:0]   addr     [2];
  logic            hit      [2];
  logic [XLEN-1:0] hit_data [2];

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    addr[0] = oprs1;
    addr[1] = oprs2;
    for (int p = 0; p < 2; p++) begin
      hit[p]      = 1'b0;
      hit_data[p] = '0;
      if (wrt_en && (oprd == addr[p])) begin
        hit[p]      = 1'b1;
        hit_data[p] = wrt_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (valid[k] && (entries[k].rd == addr[p])) begin
          hit[p]      = 1'b1;
          hit_data[p] = entries[k].data;
        end
      end
      if (addr[p] == REG_ZERO) begin
        hit[p]      = 1'b0;
        hit_data[p] = '0;
      end
    end
  end

  assign fwd1_hit  = hit[0];
  assign fwd1_data = hit_data[0];
  assign fwd2_hit  = hit[1];
  assign fwd2_data = hit_data[1];

endmodule

// File: tb/tb_rv32i_writeback.sv
// Self-checking bench for rv32i_writeback: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_rv32i_writeback;
  import rv32i_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid, wb_stall;
  logic [AW-1:0]   alu_rd, mem_rd, oprs1, oprs2;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready, wrt_en, fwd1_hit, fwd2_hit;
  logic [AW-1:0]   oprd;
  logic [XLEN-1:0] wrt_data, fwd1_data, fwd2_data;
  logic [CW-1:0]   pending;

  int n_cmp = 0;
  int n_bad = 0;

  rv32i_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .wrt_en(wrt_en), .oprd(oprd), .wrt_data(wrt_data),
    .oprs1(oprs1), .oprs2(oprs2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending writes plus the last retired write.
  wb_entry_t       mq [$];
  logic            m_en;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_data;

  function automatic void model_clear();
    mq.delete();
    m_en   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endfunction

  function automatic void model_update();
    bit        room;
    bit        took;
    wb_entry_t in;
    if (!rst) begin
      model_clear();
      return;
    end
    room = (mq.size() < DEPTH);
    took = room && (mem_valid || alu_valid);
    in   = mem_valid ? '{rd: mem_rd, data: mem_data} : '{rd: alu_rd, data: alu_data};
    if (mq.size() > 0 && !wb_stall) begin
      m_en   = 1'b1;
      m_rd   = mq[0].rd;
      m_data = mq[0].data;
      void'(mq.pop_front());
    end else begin
      m_en = 1'b0;
    end
    if (took && in.rd != 0) mq.push_back(in);
  endfunction

  function automatic void model_fwd(input logic [AW-1:0] a, output logic h, output logic [XLEN-1:0] d);
    wb_entry_t cand [$];
    h = 1'b0;
    d = '0;
    if (m_en) cand.push_back('{rd: m_rd, data: m_data});
    foreach (mq[i]) cand.push_back(mq[i]);
    if (a == 0) return;
    foreach (cand[i]) if (cand[i].rd == a) begin
      h = 1'b1;
      d = cand[i].data;
    end
  endfunction

  // Advance one clock: model follows the edge, outputs are then sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    n_cmp += 6;
    if (wrt_en !== 1'b0)   begin n_bad++; $display("FAIL reset_wrt_en: got %0b want 0", wrt_en); end
    if (oprd !== '0)       begin n_bad++; $display("FAIL reset_oprd: got %0d want 0", oprd); end
    if (wrt_data !== '0)   begin n_bad++; $display("FAIL reset_wrt_data: got %0h want 0", wrt_data); end
    if (pending !== '0)    begin n_bad++; $display("FAIL reset_pending: got %0d want 0", pending); end
    if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_alu_ready: got %0b want 0", alu_ready); end
    if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ready: got %0b want 0", mem_ready); end
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'h0000_00AA;
    #1;
    n_cmp++;
    if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %0b want 1", alu_ready); end
    cycle();
    alu_valid = 1'b0;
    n_cmp += 2;
    if (wrt_en !== 1'b0)  begin n_bad++; $display("FAIL single_early: got %0b want 0", wrt_en); end
    if (pending !== CW'(1)) begin n_bad++; $display("FAIL single_pend1: got %0d want 1", pending); end
    cycle();
    n_cmp += 4;
    if (wrt_en !== 1'b1)           begin n_bad++; $display("FAIL single_wrt_en: got %0b want 1", wrt_en); end
    if (oprd !== 5'd5)             begin n_bad++; $display("FAIL single_oprd: got %0d want 5", oprd); end
    if (wrt_data !== 32'hAA)       begin n_bad++; $display("FAIL single_data: got %0h want aa", wrt_data); end
    if (pending !== '0)            begin n_bad++; $display("FAIL single_pend0: got %0d want 0", pending); end
  endtask

  task automatic test_simultaneous();
    mem_valid = 1'b1; mem_rd = 3; mem_data = 32'h1111;
    alu_valid = 1'b1; alu_rd = 4; alu_data = 32'h2222;
    #1;
    n_cmp += 2;
    if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL simul_mem_ready: got %0b want 1", mem_ready); end
    if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL simul_alu_ready: got %0b want 0", alu_ready); end
    cycle();
    mem_valid = 1'b0;
    #1;
    n_cmp++;
    if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL simul_alu_ready2: got %0b want 1", alu_ready); end
    cycle();
    alu_valid = 1'b0;
    n_cmp += 3;
    if (wrt_en !== 1'b1 || oprd !== 5'd3 || wrt_data !== 32'h1111)
      begin n_bad++; $display("FAIL simul_first: got en=%0b rd=%0d data=%0h want 1/3/1111", wrt_en, oprd, wrt_data); end
    cycle();
    if (wrt_en !== 1'b1 || oprd !== 5'd4 || wrt_data !== 32'h2222)
      begin n_bad++; $display("FAIL simul_second: got en=%0b rd=%0d data=%0h want 1/4/2222", wrt_en, oprd, wrt_data); end
    cycle();
    if (wrt_en !== 1'b0 || pending !== '0)
      begin n_bad++; $display("FAIL simul_idle: got en=%0b pend=%0d want 0/0", wrt_en, pending); end
  endtask

  task automatic test_x0_drop();
    alu_valid = 1'b1; alu_rd = 0; alu_data = 32'hDEAD; oprs1 = 0;
    #1;
    n_cmp += 2;
    if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %0b want 1", alu_ready); end
    if (fwd1_hit !== 1'b0)  begin n_bad++; $display("FAIL x0_fwd: got %0b want 0", fwd1_hit); end
    cycle();
    alu_valid = 1'b0;
    n_cmp += 2;
    if (pending !== '0) begin n_bad++; $display("FAIL x0_pending: got %0d want 0", pending); end
    if (wrt_en !== 1'b0) begin n_bad++; $display("FAIL x0_wrt_en: got %0b want 0", wrt_en); end
    cycle();
    n_cmp++;
    if (wrt_en !== 1'b0) begin n_bad++; $display("FAIL x0_wrt_en2: got %0b want 0", wrt_en); end
  endtask

  task automatic test_fill_stall();
    logic rdy;
    wb_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      alu_valid = 1'b1; alu_rd = AW'(i); alu_data = 32'(i * 32'h100);
      #1;
      n_cmp++;
      if (alu_ready !== (i <= 4)) begin n_bad++; $display("FAIL fill_ready%0d: got %0b want %0b", i, alu_ready, i <= 4); end
      if (i <= 4) cycle();
    end
    n_cmp++;
    if (pending !== CW'(4)) begin n_bad++; $display("FAIL fill_pending: got %0d want 4", pending); end
    @(negedge clk);
    wb_stall = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      rdy = alu_ready;
      cycle();
      if (rdy) alu_valid = 1'b0;
      n_cmp++;
      if (wrt_en !== 1'b1 || oprd !== AW'(k) || wrt_data !== 32'(k * 32'h100))
        begin n_bad++; $display("FAIL fill_drain%0d: got en=%0b rd=%0d data=%0h", k, wrt_en, oprd, wrt_data); end
    end
    cycle();
    n_cmp++;
    if (wrt_en !== 1'b0 || pending !== '0)
      begin n_bad++; $display("FAIL fill_idle: got en=%0b pend=%0d want 0/0", wrt_en, pending); end
  endtask

  task automatic test_forward_youngest();
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h10;
    cycle();
    alu_data = 32'h20;
    cycle();
    alu_valid = 1'b0; oprs2 = 7;
    #1;
    n_cmp++;
    if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h20)
      begin n_bad++; $display("FAIL fwd_young: got hit=%0b data=%0h want 1/20", fwd2_hit, fwd2_data); end
    wb_stall = 1'b0;
    cycle();
    #1;
    n_cmp++;
    if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h20)
      begin n_bad++; $display("FAIL fwd_mid: got hit=%0b data=%0h want 1/20", fwd2_hit, fwd2_data); end
    cycle();
    cycle();
    #1;
    n_cmp++;
    if (fwd2_hit !== 1'b0 || fwd2_data !== '0)
      begin n_bad++; $display("FAIL fwd_gone: got hit=%0b data=%0h want 0/0", fwd2_hit, fwd2_data); end
    oprs2 = 0;
  endtask

  task automatic test_async_reset();
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = AW'(10 + i); alu_data = 32'hC0DE_0000 + 32'(i);
      cycle();
    end
    alu_valid = 1'b0; wb_stall = 1'b0;
    cycle();
    n_cmp++;
    if (wrt_en !== 1'b1 || pending !== CW'(2))
      begin n_bad++; $display("FAIL arst_pre: got en=%0b pend=%0d want 1/2", wrt_en, pending); end
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (wrt_en !== 1'b0 || pending !== '0 || oprd !== '0)
      begin n_bad++; $display("FAIL arst_now: got en=%0b pend=%0d rd=%0d want 0/0/0", wrt_en, pending, oprd); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (wrt_en !== 1'b0 || pending !== '0)
        begin n_bad++; $display("FAIL arst_stale%0d: got en=%0b pend=%0d want 0/0", i, wrt_en, pending); end
    end
  endtask

  task automatic test_random();
    bit              a_hold = 0, m_hold = 0;
    bit              exp_mr, exp_ar, a_acc, m_acc;
    logic            h1, h2;
    logic [XLEN-1:0] d1, d2;
    for (int n = 0; n < 600; n++) begin
      wb_stall = ($urandom_range(0, 3) == 0);
      if (!m_hold) begin
        mem_valid = ($urandom_range(0, 2) == 0);
        mem_rd = AW'($urandom_range(0, 7)); mem_data = $urandom;
      end
      if (!a_hold) begin
        alu_valid = ($urandom_range(0, 1) == 0);
        alu_rd = AW'($urandom_range(0, 7)); alu_data = $urandom;
      end
      oprs1 = AW'($urandom_range(0, 7));
      oprs2 = AW'($urandom_range(0, 7));
      #1;
      exp_mr = (mq.size() < DEPTH);
      exp_ar = exp_mr && !mem_valid;
      model_fwd(oprs1, h1, d1);
      model_fwd(oprs2, h2, d2);
      n_cmp++;
      if (mem_ready !== exp_mr || alu_ready !== exp_ar)
        begin n_bad++; $display("FAIL rnd_ready@%0d: got m=%0b a=%0b want %0b/%0b", n, mem_ready, alu_ready, exp_mr, exp_ar); end
      n_cmp++;
      if (fwd1_hit !== h1 || fwd1_data !== d1 || fwd2_hit !== h2 || fwd2_data !== d2)
        begin n_bad++; $display("FAIL rnd_fwd@%0d: got %0b/%0h %0b/%0h want %0b/%0h %0b/%0h", n, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, h1, d1, h2, d2); end
      m_acc = mem_valid && exp_mr;
      a_acc = alu_valid && exp_ar;
      cycle();
      m_hold = mem_valid && !m_acc;
      a_hold = alu_valid && !a_acc;
      n_cmp++;
      if (wrt_en !== m_en || oprd !== m_rd || wrt_data !== m_data || pending !== CW'(mq.size()))
        begin n_bad++; $display("FAIL rnd_out@%0d: got %0b/%0d/%0h p%0d want %0b/%0d/%0h p%0d", n, wrt_en, oprd, wrt_data, pending, m_en, m_rd, m_data, mq.size()); end
    end
    mem_valid = 1'b0; alu_valid = 1'b0; wb_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    wb_stall = 1'b0; oprs1 = '0; oprs2 = '0;
    model_clear();
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_x0_drop();
    test_fill_stall();
    test_forward_youngest();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
